// File: rtl/xbar_rx_collector.sv
// Crossbar receive collector: per-port serial framers assemble {header,payload}
// pairs; once every port has one, the combined vector is queued in a FWFT FIFO.

module xbar_rx_lane #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk10,
  input  logic          serial_in,
  input  logic          push,
  output logic          done_set,
  output logic [2*PW-1:0] vec_nxt,
  output logic          ferr
);
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   sh_q, sh_d;
  logic [PW-1:0]   hdr_q, hdr_d;
  logic [2*PW-1:0] vec_q, vec_d;
  logic            phase_q, phase_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    hdr_d    = hdr_q;
    vec_d    = vec_q;
    phase_d  = phase_q;
    done_set = done_q;
    ferr_d   = ferr_q;
    if (clk10) begin
      case (state_q)
        // A lane holding a finished pair waits for the push before listening again.
        S_IDLE: if (!done_q && !serial_in) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
        S_DATA: begin
          sh_d  = {serial_in, sh_q[PW-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(PW-1)) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (serial_in) begin
            if (!phase_q) begin
              hdr_d   = sh_q;
              phase_d = 1'b1;
            end else begin
              vec_d    = {hdr_q, sh_q};
              done_set = 1'b1;
              phase_d  = 1'b0;
            end
          end else begin
            ferr_d  = 1'b1;
            phase_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    done_d = done_set && !push;
  end

  assign vec_nxt = vec_d;
  assign ferr    = ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      hdr_q   <= '0;
      vec_q   <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      hdr_q   <= hdr_d;
      vec_q   <= vec_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end
endmodule

module xbar_rx_collector #(
  parameter int PORTS        = 8,
  parameter int PACKET_WIDTH = 8,
  parameter int DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk10,
  input  logic [PORTS-1:0]                serial_in,
  output logic [2*PORTS*PACKET_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow_err,
  output logic [PORTS-1:0]                framing_err
);
  localparam int PW   = PACKET_WIDTH;
  localparam int VW   = 2*PORTS*PW;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [PORTS-1:0]              done_set;
  logic [PORTS-1:0][2*PW-1:0]    vec_nxt;
  logic                          push;

  // Vector push is decided combinationally so the completing stop tick pushes on its own edge.
  assign push = &done_set;

  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    xbar_rx_lane #(.PW(PW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clk10    (clk10),
      .serial_in(serial_in[i]),
      .push     (push),
      .done_set (done_set[i]),
      .vec_nxt  (vec_nxt[i]),
      .ferr     (framing_err[i])
    );
  end

  logic [VW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            pop, full, wr_en;

  always_comb begin
    pop    = (cnt_q != '0) && out_ready;
    full   = (cnt_q == CNTW'(DEPTH));
    wr_en  = push && (!full || pop);
    ovf_d  = ovf_q || (push && full && !pop);
    wptr_d = wptr_q + AW'(wr_en);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + CNTW'(wr_en) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= vec_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid    = (cnt_q != '0);
  assign out_data     = out_valid ? mem_q[rptr_q] : '0;
  assign overflow_err = ovf_q;
endmodule

// File: doc/xbar_rx_collector.md
XBAR_RX_COLLECTOR -- requirements
Module: xbar_rx_collector

Interface
REQ-001 SHALL have parameter PORTS, default 8, number of crossbar output ports.
REQ-002 SHALL have parameter PACKET_WIDTH, default 8, bits per header and per payload.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clk10  input  1  bit-time strobe, one clk cycle high per 10 clk cycles.
REQ-007 SHALL have port serial_in  input  PORTS  one serial line per crossbar output port, idle high.
REQ-008 SHALL have port out_data  output  2*PORTS*PACKET_WIDTH  assembled vector; port i header at bits [2*PW*i+2*PW-1 -: PW], payload at [2*PW*i+PW-1 -: PW].
REQ-009 SHALL have port out_valid  output  1  FIFO head holds a complete vector.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-011 SHALL have port overflow_err  output  1  sticky, vector dropped on full FIFO.
REQ-012 SHALL have port framing_err  output  PORTS  sticky per port, bad stop bit seen.

Function
REQ-013 SHALL sample serial_in only in cycles where clk10 is high; other cycles SHALL NOT change the bit state machines.
REQ-014 Frame SHALL be: start bit 0, PACKET_WIDTH data bits LSB first, stop bit 1.
REQ-015 Per-port bit FSM SHALL have states IDLE, DATA, STOP: IDLE->DATA on sampled 0; DATA counts PACKET_WIDTH samples then ->STOP; STOP->IDLE always.
REQ-016 Per-port phase bit SHALL alternate: first good frame = header, second = payload; phase returns to header after payload.
REQ-017 Stop sampled 0 SHALL discard that frame, set framing_err[i], and reset that port's phase to header.
REQ-018 On good payload frame, port SHALL latch {header,payload} and set port_done[i]; a completed port SHALL ignore further start bits until the vector is pushed.
REQ-019 When all port_done bits are set, the vector SHALL be pushed into the FIFO on the clk edge of the completing clk10 cycle and all port_done cleared on that edge.
REQ-020 out_valid SHALL be high in the cycle after a push into an empty FIFO (first-word fall-through); out_data SHALL always show the FIFO head.
REQ-021 Pop SHALL occur on any edge with out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 Push when FIFO full and no pop that edge SHALL drop the vector and set overflow_err; push and pop on same edge when full SHALL succeed, count unchanged.
REQ-023 Push and pop same edge with count 1 SHALL keep out_valid high showing the new vector.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-025 Sticky errors SHALL clear only on reset.

Reset
REQ-026 While rst high: all FSMs IDLE, phases header, port_done 0, FIFO empty, out_valid 0, out_data 0, overflow_err 0, framing_err 0.
REQ-027 rst asserted mid-frame SHALL discard all partial frames and FIFO content; first frame after release SHALL be a header.
REQ-028 Start bit sampled on first clk10 after release SHALL be accepted.

Verification
REQ-029 All 8 ports send header 8'hA5+i, payload 8'h3C^i aligned, out_ready=1 -> out_valid one cycle after final stop tick, port i slice = {8'hA5+i, 8'h3C^i}, single pulse.
REQ-030 Ports staggered by 0..7 bit-times, port 7 last -> exactly one vector, pushed on port 7's payload stop tick; earlier ports' second-start glitches ignored.
REQ-031 out_ready=0, 5 vectors sent -> 4 stored, overflow_err=1 after 5th; raising out_ready yields vectors 1-4 in order, then out_valid=0.
REQ-032 Port 3 header stop bit forced 0 -> framing_err=8'h08; its next good frame treated as header; vector correct after resend.
REQ-033 FIFO full, push and pop on same edge -> no overflow_err, count stays 4, order preserved.
REQ-034 rst pulsed mid-payload on all ports with 2 vectors queued -> out_valid=0 next cycle, errors 0; fresh header/payload pair after release produces correct vector.
